// File: rtl/debounce_4ch_v.sv
// rtl/debounce_4ch_v.sv - four-channel synchroniser, debouncer and edge-pulse generator
module debounce_4ch_v #(
    parameter int   DEBOUNCE_CYCLES = 20,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_a,
    input  logic       i_b,
    input  logic       i_c,
    input  logic       i_d,
    output logic       o_a,
    output logic       o_b,
    output logic       o_c,
    output logic       o_d,
    output logic [3:0] o_rise,
    output logic [3:0] o_fall
);

    // Counter width is derived from the hold length and is not meant to be overridden.
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // Terminal count: the edge at which a held mismatch is finally accepted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Raw channels packed as bit0=a ... bit3=d.
    logic [3:0] raw;
    assign raw = {i_d, i_c, i_b, i_a};

    // Two-stage synchroniser; only the second stage is used downstream.
    logic [3:0] s1_q;
    logic [3:0] s1_d;
    logic [3:0] s2_q;
    logic [3:0] s2_d;

    // Debounced levels, per-channel hold counters and registered edge pulses.
    logic [3:0]       stable_q;
    logic [3:0]       stable_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [3:0]       rise_q;
    logic [3:0]       rise_d;
    logic [3:0]       fall_q;
    logic [3:0]       fall_d;

    // Synchroniser next state: shift each raw line one stage per clock.
    always_comb begin
        s1_d = raw;
        s2_d = s1_q;
    end

    // Debounce next state: count consecutive mismatches, accept the new level on the
    // last count, and clear on any return to the stable level (no partial credit).
    always_comb begin
        stable_d = stable_q;
        for (int n = 0; n < 4; n++) begin
            cnt_d[n] = cnt_q[n];
            if (s2_q[n] == stable_q[n]) begin
                cnt_d[n] = '0;
            end else if (cnt_q[n] == CNT_LAST) begin
                stable_d[n] = s2_q[n];
                cnt_d[n]    = '0;
            end else begin
                cnt_d[n] = cnt_q[n] + CNT_W'(1);
            end
        end
        // Pulses are registered alongside the level so they align with the new output.
        rise_d = stable_d & ~stable_q;
        fall_d = ~stable_d & stable_q;
    end

    // State registers; reset discards any in-flight count and clears the pulses.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_q     <= {4{RESET_VAL}};
            s2_q     <= {4{RESET_VAL}};
            stable_q <= {4{RESET_VAL}};
            rise_q   <= '0;
            fall_q   <= '0;
            for (int n = 0; n < 4; n++) begin
                cnt_q[n] <= '0;
            end
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            for (int n = 0; n < 4; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
        end
    end

    assign o_a    = stable_q[0];
    assign o_b    = stable_q[1];
    assign o_c    = stable_q[2];
    assign o_d    = stable_q[3];
    assign o_rise = rise_q;
    assign o_fall = fall_q;

endmodule
